serial_nibble_receiver: RTL and testbench

Framed serial receiver that sits downstream of the 4-bit left shift register stage. It consumes the single-bit stream that stage shifts through, one bit per clock. It detects a start bit and shifts the data bits in left, so the first data bit received lands in the MSB. It optionally checks even parity, validates the stop bit, and presents each completed word on a parallel output held under a valid/ack handshake.

---
 rtl/serial_nibble_receiver.sv | 142 ++++++++++++++
 tb/tb_serial_nibble_receiver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_nibble_receiver.sv
// Framed serial receiver: start bit, DATA_BITS data bits (MSB first), optional even parity (PARITY_CHECK_EN), stop bit.
// Latency: word/valid and error pulses are registered on the stop-sample edge; busy follows the FSM state directly.
// Backpressure: valid is held until ack; a good frame arriving while valid is pending without ack is dropped and sets overrun.
module serial_nibble_receiver #(
    parameter int DATA_BITS = 4
) (
    input  logic                 clockpulse,
    input  logic                 clear,
    input  logic                 serial_input,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] word,
    output logic                 valid,
    output logic                 busy,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun
);

    localparam int CW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
`ifdef PARITY_CHECK_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state, state_d;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [CW-1:0]          bit_cnt;
    logic                   start_det;
    logic                   shift_en;
    logic                   stop_smp;
    logic                   par_bad;
    logic                   good_frame;
    logic                   handshake;

    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                if (!serial_input) begin
                    start_det = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                if (bit_cnt == LAST) begin
`ifdef PARITY_CHECK_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: state_d = STOP;
`endif
            STOP: begin
                stop_smp = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign handshake  = valid & ack;
    assign good_frame = stop_smp & serial_input & ~par_bad;

`ifdef PARITY_CHECK_EN
    logic par_err_q;
    logic parity_error_q;

    // Mismatch is latched in PARITY and only reported if the stop bit is good.
    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) begin
            par_err_q      <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            parity_error_q <= stop_smp & serial_input & par_err_q;
            if (start_det)
                par_err_q <= 1'b0;
            else if (state == PARITY)
                par_err_q <= (^shift_reg) ^ serial_input;
        end
    end

    assign par_bad      = par_err_q;
    assign parity_error = parity_error_q;
`else
    assign par_bad      = 1'b0;
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) begin
            shift_reg     <= '0;
            bit_cnt       <= '0;
            word          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= stop_smp & ~serial_input;

            if (start_det) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[DATA_BITS-2:0], serial_input};
                bit_cnt   <= bit_cnt + 1'b1;
            end

            // A frame landing on the same edge as ack replaces the consumed word.
            if (good_frame && (!valid || ack)) begin
                word  <= shift_reg;
                valid <= 1'b1;
            end else if (handshake) begin
                valid <= 1'b0;
            end

            if (good_frame && valid && !ack)
                overrun <= 1'b1;
            else if (handshake)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_nibble_receiver.sv
// Directed bench for serial_nibble_receiver (DATA_BITS = 4); follows PARITY_CHECK_EN for frame format.
module tb_serial_nibble_receiver;

    logic       clockpulse;
    logic       clear;
    logic       serial_input;
    logic       ack;
    logic [3:0] word;
    logic       valid;
    logic       busy;
    logic       framing_error;
    logic       parity_error;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef PARITY_CHECK_EN
    localparam int FRAME_LEN = 7;
`else
    localparam int FRAME_LEN = 6;
`endif

    serial_nibble_receiver #(.DATA_BITS(4)) dut (
        .clockpulse    (clockpulse),
        .clear         (clear),
        .serial_input  (serial_input),
        .ack           (ack),
        .word          (word),
        .valid         (valid),
        .busy          (busy),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .overrun       (overrun)
    );

    initial clockpulse = 1'b0;
    always #5 clockpulse = ~clockpulse;

    typedef struct {
        logic [3:0] data;
        bit         bad_par;
        bit         stop;
        bit         ack_stop;
        bit         ack_idle;
        bit         par_only;
        logic [3:0] exp_word;
        bit         exp_valid;
        bit         exp_fe;
        bit         exp_pe;
        bit         exp_ovr;
        bit         exp_valid2;
        bit         exp_ovr2;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        serial_input = b;
        @(posedge clockpulse);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] d, input bit bad_par, input bit stop, input bit ack_stop);
        send_bit(1'b0);
        chk("busy_after_start", {7'd0, busy}, 8'd1);
        for (int i = 3; i >= 0; i--) send_bit(d[i]);
`ifdef PARITY_CHECK_EN
        send_bit((^d) ^ bad_par);
`endif
        ack = ack_stop;
        send_bit(stop);
        ack = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_word"}, {4'd0, word}, 8'd0);
        chk({name, "_flags"}, {3'd0, valid, busy, framing_error, parity_error, overrun}, 8'd0);
    endtask

    vec_t vecs[8];
    int   fe_count;

    initial begin
        //         data     bp stop aS aI po  exp_word v  fe pe ov v2 ov2
        vecs[0] = '{4'b1011, 0, 1,  0, 1, 0, 4'b1011, 1, 0, 0, 0, 0, 0};
        vecs[1] = '{4'b1011, 1, 1,  0, 0, 1, 4'b1011, 0, 0, 1, 0, 0, 0};
        vecs[2] = '{4'b1011, 0, 0,  0, 0, 0, 4'b1011, 0, 1, 0, 0, 0, 0};
        vecs[3] = '{4'b0011, 0, 1,  0, 0, 0, 4'b0011, 1, 0, 0, 0, 1, 0};
        vecs[4] = '{4'b1100, 0, 1,  0, 1, 0, 4'b0011, 1, 0, 0, 1, 0, 0};
        vecs[5] = '{4'b0101, 0, 1,  0, 0, 0, 4'b0101, 1, 0, 0, 0, 1, 0};
        vecs[6] = '{4'b0110, 0, 1,  1, 1, 0, 4'b0110, 1, 0, 0, 0, 0, 0};
        vecs[7] = '{4'b1111, 1, 0,  0, 1, 0, 4'b0110, 0, 1, 0, 0, 0, 0};

        // Reset held with the line toggling.
        clear        = 1'b1;
        serial_input = 1'b1;
        ack          = 1'b0;
        #1 clear = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        chk_all_zero("reset_hold");
        clear = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        chk_all_zero("reset_idle");

        for (int i = 0; i < 8; i++) begin
`ifndef PARITY_CHECK_EN
            if (vecs[i].par_only) continue;
`endif
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop, vecs[i].ack_stop);
            chk($sformatf("v%0d_word", i), {4'd0, word}, {4'd0, vecs[i].exp_word});
            chk($sformatf("v%0d_flags", i), {4'd0, valid, framing_error, parity_error, overrun},
                {4'd0, vecs[i].exp_valid, vecs[i].exp_fe, vecs[i].exp_pe, vecs[i].exp_ovr});
            chk($sformatf("v%0d_busy_stop", i), {7'd0, busy}, 8'd0);
            ack = vecs[i].ack_idle;
            send_bit(1'b1);
            ack = 1'b0;
            chk($sformatf("v%0d_after", i), {3'd0, valid, busy, framing_error, parity_error, overrun},
                {3'd0, vecs[i].exp_valid2, 1'b0, 1'b0, 1'b0, vecs[i].exp_ovr2});
            chk($sformatf("v%0d_word_held", i), {4'd0, word}, {4'd0, vecs[i].exp_word});
        end

        // Stuck-low line: one framing error per frame length, no lock-up.
        fe_count = 0;
        serial_input = 1'b0;
        for (int c = 0; c < 3 * FRAME_LEN; c++) begin
            @(posedge clockpulse);
            #1;
            if (framing_error) fe_count++;
        end
        chk("stuck_low_fe_count", fe_count[7:0], 8'd3);
        chk("stuck_low_valid", {7'd0, valid}, 8'd0);
        send_bit(1'b1);
        chk("stuck_low_recover_busy", {7'd0, busy}, 8'd0);

        // Back-to-back frames without idle gap; second one overruns.
        send_frame(4'b1001, 0, 1, 0);
        send_frame(4'b0110, 0, 1, 0);
        chk("b2b_word", {4'd0, word}, 8'h09);
        chk("b2b_valid_ovr", {6'd0, valid, overrun}, 8'd3);
        ack = 1'b1;
        send_bit(1'b1);
        ack = 1'b0;
        chk("b2b_ack", {6'd0, valid, overrun}, 8'd0);
        send_bit(1'b1);
        chk("ack_idle_ignored", {6'd0, valid, overrun}, 8'd0);

        // Mid-frame asynchronous reset, then a clean frame.
        send_frame(4'b0101, 0, 1, 0);
        chk("pre_reset_valid", {7'd0, valid}, 8'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #2 clear = 1'b0;
        #1 chk_all_zero("mid_reset");
        #2 clear = 1'b1;
        send_bit(1'b1);
        chk_all_zero("mid_reset_idle");
        send_frame(4'b1001, 0, 1, 0);
        chk("post_reset_word", {4'd0, word}, 8'h09);
        chk("post_reset_flags", {4'd0, valid, framing_error, parity_error, overrun}, 8'h08);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
